imem_responder: RTL and testbench

//  Responder (memory side) of the CPU instruction-fetch interface: accepts a fetch request
//  (byte address), returns the addressed 32-bit instruction word after a fixed latency.

---
 rtl/imem_responder.sv | 86 ++++++++
 tb/tb_imem_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction-fetch responder: accepts one byte-addressed fetch at a time and returns the
// addressed 32-bit word (or NOP with an error flag) after a fixed latency.
module imem_responder #(
   parameter int          DEPTH   = 256,
   parameter int          LATENCY = 2,
   parameter logic [31:0] NOP     = 32'h0000_0013
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  logic [31:0]              req_addr_i,
   output logic                     rsp_valid_o,
   input  logic                     rsp_ready_i,
   output logic [31:0]              rsp_data_o,
   output logic                     rsp_err_o,
   input  logic                     ld_en_i,
   input  logic [$clog2(DEPTH)-1:0] ld_addr_i,
   input  logic [31:0]              ld_data_i
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]    state;
   logic [3:0]    cnt;
   logic          running;
   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] rd_idx;
   logic          addr_err;
   logic          accept;

   assign rd_idx   = req_addr_i[AW+1:2];
   assign addr_err = (req_addr_i[1:0] != 2'b00) || ((req_addr_i >> (AW + 2)) != 32'd0);

   // running keeps req_ready_o low until the first edge after reset release
   assign req_ready_o = running && (state == IDLE);
   assign accept      = req_valid_i && req_ready_o;
   assign rsp_valid_o = (state == RESP);

   // The store is deliberately left out of reset so loaded programs survive a reset
   always_ff @(posedge clk_i) begin
      if (ld_en_i) begin
         mem[ld_addr_i] <= ld_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state      <= IDLE;
         cnt        <= '0;
         running    <= 1'b0;
         rsp_data_o <= '0;
         rsp_err_o  <= 1'b0;
      end else begin
         running <= 1'b1;
         case (state)
            IDLE: begin
               if (accept) begin
                  // mem read sees the pre-edge contents, so a same-cycle load returns the old word
                  rsp_data_o <= addr_err ? NOP : mem[rd_idx];
                  rsp_err_o  <= addr_err;
                  cnt        <= 4'(LATENCY - 1);
                  state      <= (LATENCY == 1) ? RESP : WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready_i) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: table-driven fetches plus hand-written sequences for
// back-to-back, stall, same-cycle load and mid-transaction reset.
module tb_imem_responder;

   localparam int          DEPTH   = 256;
   localparam int          LATENCY = 2;
   localparam logic [31:0] NOP     = 32'h0000_0013;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [31:0] req_addr_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [31:0] rsp_data_o;
   logic        rsp_err_o;
   logic        ld_en_i;
   logic [7:0]  ld_addr_i;
   logic [31:0] ld_data_i;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] exp_data;
      logic        exp_err;
   } vec_t;

   vec_t vecs [8];

   imem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY), .NOP(NOP)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_addr_i  (req_addr_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rsp_data_o  (rsp_data_o),
      .rsp_err_o   (rsp_err_o),
      .ld_en_i     (ld_en_i),
      .ld_addr_i   (ld_addr_i),
      .ld_data_i   (ld_data_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic loadWord(input logic [7:0] idx, input logic [31:0] data);
      ld_en_i   = 1'b1;
      ld_addr_i = idx;
      ld_data_i = data;
      @(posedge clk_i);
      @(negedge clk_i);
      ld_en_i = 1'b0;
   endtask

   // Called at a falling edge with the responder idle; returns the word, error and cycles to valid
   task automatic applyStimulus(input logic [31:0] addr, output logic [31:0] data,
                                output logic err, output int lat);
      req_valid_i = 1'b1;
      req_addr_i  = addr;
      rsp_ready_i = 1'b0;
      checkOutput("req_ready_idle", 32'(req_ready_o), 32'd1);
      @(posedge clk_i);
      @(negedge clk_i);
      req_valid_i = 1'b0;
      req_addr_i  = 32'hFFFF_FFFF;
      lat = 1;
      while (!rsp_valid_o && lat < 20) begin
         @(negedge clk_i);
         lat++;
      end
      data = rsp_data_o;
      err  = rsp_err_o;
      rsp_ready_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      rsp_ready_i = 1'b0;
      checkOutput("rsp_valid_drop", 32'(rsp_valid_o), 32'd0);
      checkOutput("req_ready_back", 32'(req_ready_o), 32'd1);
   endtask

   initial begin
      logic [31:0] data;
      logic        err;
      int          lat;

      vecs[0] = '{32'h0000_0000, 32'h0050_0093, 1'b0};
      vecs[1] = '{32'h0000_0004, 32'h0062_0113, 1'b0};
      vecs[2] = '{32'h0000_0008, 32'h00A0_0193, 1'b0};
      vecs[3] = '{32'h0000_03FC, 32'hCAFE_F00D, 1'b0};
      vecs[4] = '{32'h0000_0002, NOP,           1'b1};
      vecs[5] = '{32'h0000_0400, NOP,           1'b1};
      vecs[6] = '{32'h0000_0001, NOP,           1'b1};
      vecs[7] = '{32'hFFFF_FFFC, NOP,           1'b1};

      rst_i       = 1'b0;
      req_valid_i = 1'b0;
      req_addr_i  = '0;
      rsp_ready_i = 1'b0;
      ld_en_i     = 1'b0;
      ld_addr_i   = '0;
      ld_data_i   = '0;

      #12;
      checkOutput("rst_req_ready", 32'(req_ready_o), 32'd0);
      checkOutput("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      checkOutput("rst_rsp_data", rsp_data_o, 32'd0);
      checkOutput("rst_rsp_err", 32'(rsp_err_o), 32'd0);

      @(negedge clk_i);
      loadWord(8'd0, 32'h0050_0093);
      loadWord(8'd1, 32'h0062_0113);
      loadWord(8'd2, 32'h00A0_0193);
      loadWord(8'd3, 32'h1234_5678);
      loadWord(8'd255, 32'hCAFE_F00D);
      checkOutput("rst_hold_req_ready", 32'(req_ready_o), 32'd0);
      rst_i = 1'b1;
      checkOutput("release_req_ready_pre_edge", 32'(req_ready_o), 32'd0);
      @(posedge clk_i);
      @(negedge clk_i);
      checkOutput("release_req_ready", 32'(req_ready_o), 32'd1);

      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].addr, data, err, lat);
         checkOutput($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
         checkOutput($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
         checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(LATENCY));
      end

      // Back-to-back with req_valid_i held high
      req_valid_i = 1'b1;
      req_addr_i  = 32'h0;
      rsp_ready_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      req_addr_i = 32'h4;
      checkOutput("b2b_wait_ready", 32'(req_ready_o), 32'd0);
      checkOutput("b2b_wait_valid", 32'(rsp_valid_o), 32'd0);
      @(negedge clk_i);
      checkOutput("b2b_rsp1_valid", 32'(rsp_valid_o), 32'd1);
      checkOutput("b2b_rsp1_data", rsp_data_o, 32'h0050_0093);
      checkOutput("b2b_rsp1_ready", 32'(req_ready_o), 32'd0);
      @(negedge clk_i);
      checkOutput("b2b_idle_valid", 32'(rsp_valid_o), 32'd0);
      checkOutput("b2b_idle_ready", 32'(req_ready_o), 32'd1);
      @(negedge clk_i);
      req_valid_i = 1'b0;
      checkOutput("b2b_second_wait", 32'(rsp_valid_o), 32'd0);
      @(negedge clk_i);
      checkOutput("b2b_rsp2_valid", 32'(rsp_valid_o), 32'd1);
      checkOutput("b2b_rsp2_data", rsp_data_o, 32'h0062_0113);
      @(negedge clk_i);
      checkOutput("b2b_no_dup", 32'(rsp_valid_o), 32'd0);
      rsp_ready_i = 1'b0;

      // Response stalled for five cycles
      req_valid_i = 1'b1;
      req_addr_i  = 32'hC;
      @(posedge clk_i);
      @(negedge clk_i);
      req_valid_i = 1'b0;
      @(negedge clk_i);
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("stall%0d_valid", i), 32'(rsp_valid_o), 32'd1);
         checkOutput($sformatf("stall%0d_data", i), rsp_data_o, 32'h1234_5678);
         checkOutput($sformatf("stall%0d_ready", i), 32'(req_ready_o), 32'd0);
         @(negedge clk_i);
      end
      checkOutput("stall_end_valid", 32'(rsp_valid_o), 32'd1);
      rsp_ready_i = 1'b1;
      @(negedge clk_i);
      rsp_ready_i = 1'b0;
      checkOutput("stall_release_valid", 32'(rsp_valid_o), 32'd0);
      checkOutput("stall_release_ready", 32'(req_ready_o), 32'd1);

      // Load the same index in the accept cycle: old word comes back
      req_valid_i = 1'b1;
      req_addr_i  = 32'h8;
      ld_en_i     = 1'b1;
      ld_addr_i   = 8'd2;
      ld_data_i   = 32'hDEAD_BEEF;
      @(posedge clk_i);
      @(negedge clk_i);
      req_valid_i = 1'b0;
      ld_en_i     = 1'b0;
      @(negedge clk_i);
      checkOutput("ldsame_valid", 32'(rsp_valid_o), 32'd1);
      checkOutput("ldsame_old_word", rsp_data_o, 32'h00A0_0193);
      rsp_ready_i = 1'b1;
      @(negedge clk_i);
      rsp_ready_i = 1'b0;
      applyStimulus(32'h8, data, err, lat);
      checkOutput("ldsame_new_word", data, 32'hDEAD_BEEF);

      // Reset asserted while the request is in WAIT
      req_valid_i = 1'b1;
      req_addr_i  = 32'h4;
      @(posedge clk_i);
      @(negedge clk_i);
      req_valid_i = 1'b0;
      rsp_ready_i = 1'b1;
      rst_i = 1'b0;
      #1;
      checkOutput("midrst_valid", 32'(rsp_valid_o), 32'd0);
      checkOutput("midrst_ready", 32'(req_ready_o), 32'd0);
      @(negedge clk_i);
      rst_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         checkOutput($sformatf("midrst_no_rsp%0d", i), 32'(rsp_valid_o), 32'd0);
      end
      rsp_ready_i = 1'b0;
      applyStimulus(32'h0, data, err, lat);
      checkOutput("midrst_store_kept", data, 32'h0050_0093);
      checkOutput("midrst_latency", 32'(lat), 32'(LATENCY));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
